// File: rtl/bbot_quad_pkg.sv
// Shared quadrature definitions: controller states, phase index type and
// the phase-to-(A,B) encoding used by the generator and the counter bench.
package bbot_quad_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic [1:0] phase_t;

    // (A,B) levels for each phase index; stepping p up makes A lead B
    localparam logic [1:0] AB_P0 = 2'b00;
    localparam logic [1:0] AB_P1 = 2'b10;
    localparam logic [1:0] AB_P2 = 2'b11;
    localparam logic [1:0] AB_P3 = 2'b01;

    function automatic logic [1:0] phase_to_ab(input phase_t p);
        logic [1:0] ab;
        case (p)
            2'd0:    ab = AB_P0;
            2'd1:    ab = AB_P1;
            2'd2:    ab = AB_P2;
            default: ab = AB_P3;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/bbot_edge_timer.sv
// Loadable down-counter: after a load of H it ticks for one cycle every H
// enabled clocks, reloading itself from the latched period on each tick.
module bbot_edge_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic             run,
    output logic             tick
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;

    assign tick = run && (count_q == WIDTH'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
        end else if (load) begin
            count_q  <= period;
            reload_q <= period;
        end else if (run) begin
            if (tick) begin
                count_q <= reload_q;
            end else if (count_q != '0) begin
                count_q <= count_q - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/bbot_quadrature_generator.sv
// Quadrature edge generator: emits step_count A/B edges spaced half_period
// clocks apart, in up or down phase order, with abort and done reporting.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; A/B hold the current phase
//   ST_RUN  | emitting edges on each timer tick until the count runs out
module bbot_quadrature_generator
    import bbot_quad_pkg::*;
#(
    parameter int STEP_WIDTH = 32,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dir,
    input  logic [STEP_WIDTH-1:0] step_count,
    input  logic [DIV_WIDTH-1:0]  half_period,
    input  logic                  abort,
    output logic                  A,
    output logic                  B,
    output logic                  busy,
    output logic                  done,
    output logic [STEP_WIDTH-1:0] steps_remaining
);

    state_t                state_q;
    state_t                state_d;
    phase_t                phase_q;
    phase_t                phase_next;
    logic [1:0]            ab_q;
    logic                  dir_q;
    logic [STEP_WIDTH-1:0] steps_q;
    logic                  done_q;

    logic                  accept;
    logic                  emit;
    logic                  last_edge;
    logic                  timer_load;
    logic                  timer_run;
    logic                  tick;
    logic [DIV_WIDTH-1:0]  h_eff;

    assign h_eff = (half_period == '0) ? DIV_WIDTH'(1) : half_period;

    bbot_edge_timer #(
        .WIDTH (DIV_WIDTH)
    ) u_edge_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (timer_load),
        .period (h_eff),
        .run    (timer_run),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort is checked ahead of the tick so a coinciding final edge is dropped
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        emit       = 1'b0;
        last_edge  = 1'b0;
        timer_load = 1'b0;
        timer_run  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (step_count != '0) begin
                        state_d    = ST_RUN;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_run = 1'b1;
                    if (tick && (steps_q != '0)) begin
                        emit = 1'b1;
                        if (steps_q == STEP_WIDTH'(1)) begin
                            last_edge = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign phase_next = dir_q ? (phase_q + 2'd1) : (phase_q - 2'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= 2'd0;
            ab_q    <= AB_P0;
            dir_q   <= 1'b0;
            steps_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (accept && (step_count == '0)) || last_edge;
            if (accept) begin
                dir_q   <= dir;
                steps_q <= step_count;
            end else if (emit) begin
                phase_q <= phase_next;
                ab_q    <= phase_to_ab(phase_next);
                steps_q <= steps_q - STEP_WIDTH'(1);
            end
        end
    end

    assign A               = ab_q[1];
    assign B               = ab_q[0];
    assign busy            = (state_q == ST_RUN);
    assign done            = done_q;
    assign steps_remaining = steps_q;

endmodule

// File: tb/tb_bbot_quadrature_generator.sv
// Directed bench for bbot_quadrature_generator with an up/down quadrature
// counter model fed from the A/B outputs.
module tb_bbot_quadrature_generator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [31:0] step_count = '0;
    logic [15:0] half_period = '0;
    logic        abort = 1'b0;
    logic        A;
    logic        B;
    logic        busy;
    logic        done;
    logic [31:0] steps_remaining;

    int nvec = 0;
    int nerr = 0;

    bbot_quadrature_generator dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .dir             (dir),
        .step_count      (step_count),
        .half_period     (half_period),
        .abort           (abort),
        .A               (A),
        .B               (B),
        .busy            (busy),
        .done            (done),
        .steps_remaining (steps_remaining)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Quadrature counter model: +1 for an A-leads-B step, -1 for the reverse
    function automatic logic [1:0] ab_up(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ab_down(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    logic [31:0] qcnt = 32'h8000_0000;
    logic [1:0]  prev_ab = 2'b00;
    int          edge_cnt = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          illegal_cnt = 0;
    int          edge_cyc [0:255];

    always @(negedge clock) begin
        logic [1:0] ab_now;
        ab_now = {A, B};
        if (!$isunknown(ab_now)) begin
            if (ab_now !== prev_ab) begin
                if (ab_now == ab_up(prev_ab)) qcnt = qcnt + 32'd1;
                else if (ab_now == ab_down(prev_ab)) qcnt = qcnt - 32'd1;
                else illegal_cnt = illegal_cnt + 1;
                if (edge_cnt < 256) edge_cyc[edge_cnt] = cyc;
                edge_cnt = edge_cnt + 1;
            end
            prev_ab = ab_now;
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec = nvec + 1;
        assert (obs === exp) else begin
            nerr = nerr + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic issue(input logic d, input logic [31:0] n, input logic [15:0] h, output int acc);
        start       = 1'b1;
        dir         = d;
        step_count  = n;
        half_period = h;
        cycles(1);
        start = 1'b0;
        acc   = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cycles(1);
        end
        chk(tag, seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int e0;
        int d0;
        int b0;
        logic [31:0] q0;

        cycles(3);
        reset = 1'b0;
        chk("rst_ab", {A, B}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_steps", steps_remaining, 32'd0);

        // up, 8 steps, H=4
        e0 = edge_cnt;
        d0 = done_cnt;
        issue(1'b1, 32'd8, 16'd4, acc);
        chk("t1_busy", busy, 1'b1);
        chk("t1_steps_load", steps_remaining, 32'd8);
        cycles(4);
        chk("t1_first_ab", {A, B}, 2'b10);
        chk("t1_steps_dec", steps_remaining, 32'd7);
        wait_done("t1_done_tmo", 100);
        chk("t1_done_busy", busy, 1'b0);
        chk("t1_done_steps", steps_remaining, 32'd0);
        chk("t1_done_cyc", cyc - acc, 32);
        cycles(1);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_edges", edge_cnt - e0, 8);
        chk("t1_first_lat", edge_cyc[e0] - acc, 4);
        chk("t1_span", edge_cyc[e0 + 7] - edge_cyc[e0], 28);
        chk("t1_qcnt", qcnt, 32'h8000_0008);
        chk("t1_ab_end", {A, B}, 2'b00);

        // down, 3 steps, H=1
        e0 = edge_cnt;
        issue(1'b0, 32'd3, 16'd1, acc);
        wait_done("t2_done_tmo", 20);
        cycles(1);
        chk("t2_edges", edge_cnt - e0, 3);
        chk("t2_first_lat", edge_cyc[e0] - acc, 1);
        chk("t2_span", edge_cyc[e0 + 2] - edge_cyc[e0], 2);
        chk("t2_qcnt", qcnt, 32'h8000_0005);
        chk("t2_ab_end", {A, B}, 2'b10);

        // zero-step command
        e0 = edge_cnt;
        b0 = busy_cnt;
        issue(1'b1, 32'd0, 16'd5, acc);
        chk("t3_done", done, 1'b1);
        chk("t3_busy", busy, 1'b0);
        cycles(1);
        chk("t3_done_fall", done, 1'b0);
        cycles(3);
        chk("t3_busy_cnt", busy_cnt - b0, 0);
        chk("t3_edges", edge_cnt - e0, 0);
        chk("t3_ab", {A, B}, 2'b10);

        // abort after 4 of 10 edges at H=2
        e0 = edge_cnt;
        d0 = done_cnt;
        issue(1'b1, 32'd10, 16'd2, acc);
        cycles(8);
        chk("t4_edges_pre", edge_cnt - e0, 4);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        chk("t4_busy", busy, 1'b0);
        chk("t4_steps", steps_remaining, 32'd6);
        cycles(10);
        chk("t4_edges_post", edge_cnt - e0, 4);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_steps_hold", steps_remaining, 32'd6);
        chk("t4_ab", {A, B}, 2'b10);

        // abort coinciding with the final edge tick
        e0 = edge_cnt;
        d0 = done_cnt;
        issue(1'b1, 32'd2, 16'd3, acc);
        cycles(5);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        cycles(3);
        chk("t4c_edges", edge_cnt - e0, 1);
        chk("t4c_steps", steps_remaining, 32'd1);
        chk("t4c_no_done", done_cnt - d0, 0);
        chk("t4c_ab", {A, B}, 2'b11);

        // abort while idle
        abort = 1'b1;
        cycles(2);
        abort = 1'b0;
        chk("t4i_busy", busy, 1'b0);
        chk("t4i_steps", steps_remaining, 32'd1);
        chk("t4i_ab", {A, B}, 2'b11);

        // second start while busy is ignored
        e0 = edge_cnt;
        q0 = qcnt;
        issue(1'b0, 32'd4, 16'd3, acc);
        cycles(2);
        start       = 1'b1;
        dir         = 1'b1;
        step_count  = 32'd20;
        half_period = 16'd1;
        cycles(1);
        start = 1'b0;
        chk("t5_steps_mid", steps_remaining, 32'd3);
        wait_done("t5_done_tmo", 50);
        chk("t5_done_cyc", cyc - acc, 12);
        cycles(1);
        chk("t5_edges", edge_cnt - e0, 4);
        chk("t5_qcnt", qcnt, q0 - 32'd4);
        chk("t5_ab", {A, B}, 2'b11);
        chk("t5_steps", steps_remaining, 32'd0);
        chk("t5_busy", busy, 1'b0);

        // half_period 0 acts as 1
        e0 = edge_cnt;
        issue(1'b1, 32'd2, 16'd0, acc);
        wait_done("t6_done_tmo", 20);
        cycles(1);
        chk("t6_edges", edge_cnt - e0, 2);
        chk("t6_first_lat", edge_cyc[e0] - acc, 1);
        chk("t6_gap", edge_cyc[e0 + 1] - edge_cyc[e0], 1);
        chk("t6_ab", {A, B}, 2'b00);

        // reset in the middle of a run
        d0 = done_cnt;
        issue(1'b1, 32'd10, 16'd0, acc);
        cycles(3);
        chk("t7_ab_mid", {A, B}, 2'b01);
        chk("t7_steps_mid", steps_remaining, 32'd7);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk("t7_ab", {A, B}, 2'b00);
        chk("t7_busy", busy, 1'b0);
        chk("t7_steps", steps_remaining, 32'd0);
        b0 = busy_cnt;
        cycles(5);
        chk("t7_no_done", done_cnt - d0, 0);
        chk("t7_idle", busy_cnt - b0, 0);
        chk("illegal_steps", illegal_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bbot_quadrature_generator.md
BBOT_QUADRATURE_GENERATOR -- requirements
Module: bbot_quadrature_generator

Interface
REQ-001 SHALL have parameter STEP_WIDTH, default 32: width of the step count and remaining-steps bus.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of the half-period (clocks-per-edge) input.
REQ-003 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  command strobe, sampled each clock.
REQ-007 dir  input  1  1 = count-up sequence, 0 = count-down; latched on accept.
REQ-008 step_count  input  STEP_WIDTH  number of quadrature edges to emit; latched on accept.
REQ-009 half_period  input  DIV_WIDTH  clocks between successive edges; latched on accept.
REQ-010 abort  input  1  terminates an active command.
REQ-011 A  output  1  quadrature channel A, registered.
REQ-012 B  output  1  quadrature channel B, registered.
REQ-013 busy  output  1  high while a command is running.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 steps_remaining  output  STEP_WIDTH  edges still to emit.

Function
REQ-016 SHALL implement states IDLE and RUN; IDLE->RUN on accepted start; RUN->IDLE on last edge or abort.
REQ-017 SHALL use phase index p, encoded as (A,B): p0=00, p1=10, p2=11, p3=01.
REQ-018 SHALL advance p by +1 mod 4 per edge when dir=1 and by -1 mod 4 when dir=0, so exactly one of A/B changes per edge.
REQ-019 Up sequence SHALL make the team's quadrature counter increment once per edge; down sequence SHALL make it decrement once per edge.
REQ-020 SHALL accept start only in IDLE; start in RUN is ignored and latched values are unchanged.
REQ-021 On accepted start with step_count != 0: busy=1 next cycle, steps_remaining=step_count.
REQ-022 On accepted start with step_count = 0: done pulses next cycle, busy stays 0, A/B unchanged.
REQ-023 half_period = 0 SHALL be treated as 1.
REQ-024 First A/B transition SHALL be visible H cycles after the accepting edge (H = effective half_period); each later transition follows H cycles after the previous one.
REQ-025 steps_remaining SHALL decrement in the same cycle each transition becomes visible.
REQ-026 On the final edge: done=1 and busy=0 in the same cycle the last transition becomes visible, steps_remaining=0.
REQ-027 abort in RUN: IDLE next cycle, busy=0, no done pulse; A/B hold their current level; steps_remaining holds the un-emitted count.
REQ-028 abort and final-edge timing in the same cycle: abort wins; no edge emitted; no done pulse.
REQ-029 abort in IDLE SHALL have no effect.
REQ-030 Phase SHALL persist across commands: A/B never jump, and a new command continues from the current p.
REQ-031 Divider and step arithmetic SHALL be unsigned; no wrap below 0.

Reset
REQ-032 Reset SHALL force IDLE, p0 (A=0, B=0), busy=0, done=0, steps_remaining=0 and divider=0, overriding start and abort.
REQ-033 Reset mid-RUN SHALL drop the command with no done pulse; A/B read 00 in the following cycle.

Structure
REQ-034 Shared package bbot_quad_pkg SHALL hold the state enum, the 2-bit phase type and the four phase-to-(A,B) constants, for use by this block and the quadrature counter bench.
REQ-035 One sub-module, bbot_edge_timer, SHALL be used: a loadable down-counter producing a one-cycle tick every H clocks.

Verification
REQ-036 Reset, then start with dir=1, step_count=8, half_period=4, feeding A/B into the quadrature counter -> counter reads 0x80000008; edges 4 clocks apart; done pulses once; A/B back at 00.
REQ-037 Then start with dir=0, step_count=3, half_period=1 -> edges on 3 consecutive cycles; counter reads 0x80000005; (A,B) ends at 10.
REQ-038 start with step_count=0 -> done pulses next cycle; busy never asserts; A/B unchanged.
REQ-039 Start 10 steps at H=2 and assert abort after 4 edges -> busy falls; no done pulse; steps_remaining=6; A/B static.
REQ-040 Second start while busy -> ignored: original step count and dir complete unchanged.
REQ-041 half_period=0 with 2 steps -> edges on consecutive cycles; reset asserted mid-run -> A=B=0, busy=0, no done pulse.
